// File: rtl/game_pkg.sv
// Shared game definitions: screen codes, round FSM states,
// default round parameters and level helpers.
package game_pkg;

    typedef enum logic [3:0] {
        SCR_SM = 4'd0,
        SCR_LS = 4'd1,
        SCR_GO = 4'd2,
        SCR_L1 = 4'd3,
        SCR_L2 = 4'd4,
        SCR_L3 = 4'd5,
        SCR_L4 = 4'd6,
        SCR_L5 = 4'd7,
        SCR_L6 = 4'd8,
        SCR_L7 = 4'd9,
        SCR_L8 = 4'd10
    } screen_e;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_LOAD,
        RS_SERVE,
        RS_PLAY,
        RS_WIN,
        RS_LOSE,
        RS_DONE
    } round_state_e;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_SERVE_FRAMES = 120;
    localparam int BRICKS_PER_LEVEL = 8;

    function automatic logic is_level(input logic [3:0] s);
        return (s >= SCR_L1) && (s <= SCR_L8);
    endfunction

    // Level index is the screen code minus two (L1 = 3).
    function automatic logic [6:0] level_bricks(input logic [3:0] s);
        logic [3:0] idx;
        idx = s - 4'd2;
        return 7'(BRICKS_PER_LEVEL * int'(idx));
    endfunction

endpackage

// File: rtl/round_ctrl_serve_timer.sv
// Serve-phase frame counter: counts frame ticks while enabled,
// flags the terminal count.
module serve_timer #(
    parameter int FRAMES = 120
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic term
);

    logic [7:0] cnt;

    assign term = (cnt == 8'(FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (tick && !term) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Round controller: level load, serve/play phases, lives,
// brick count, score and win/lose pulses.
module round_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = DEF_LIVES,
    parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES,
    parameter int PTS_PER_BRICK = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  screen_state,
    input  logic        brick_hit,
    input  logic        ball_lost,
    input  logic        launch_btn,
    input  logic        frame_tick,
    output logic        win,
    output logic        lose,
    output logic        ball_hold,
    output logic        play_active,
    output logic [1:0]  lives,
    output logic [6:0]  bricks_left,
    output logic [15:0] score
);

    round_state_e state;
    logic         serve_term;
    logic         serve_clr;
    logic         last_brick;
    logic [16:0]  score_sum;

    assign serve_clr  = (state != RS_SERVE);
    assign last_brick = brick_hit && (bricks_left == 7'd1);
    assign score_sum  = {1'b0, score} + 17'(PTS_PER_BRICK);

    serve_timer #(
        .FRAMES(SERVE_FRAMES)
    ) u_serve_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (serve_clr),
        .tick (frame_tick),
        .term (serve_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RS_IDLE;
            win         <= 1'b0;
            lose        <= 1'b0;
            ball_hold   <= 1'b0;
            play_active <= 1'b0;
            lives       <= 2'd0;
            bricks_left <= 7'd0;
            score       <= 16'd0;
        end else begin
            win  <= 1'b0;
            lose <= 1'b0;
            // Leaving the level screen aborts the round silently.
            if (state != RS_IDLE && !is_level(screen_state)) begin
                state       <= RS_IDLE;
                ball_hold   <= 1'b0;
                play_active <= 1'b0;
                lives       <= 2'd0;
                bricks_left <= 7'd0;
                score       <= 16'd0;
            end else begin
                unique case (state)
                    RS_IDLE: begin
                        if (is_level(screen_state)) begin
                            state <= RS_LOAD;
                        end
                    end
                    RS_LOAD: begin
                        lives       <= 2'(LIVES_INIT);
                        bricks_left <= level_bricks(screen_state);
                        score       <= 16'd0;
                        ball_hold   <= 1'b1;
                        state       <= RS_SERVE;
                    end
                    RS_SERVE: begin
                        if (launch_btn || (frame_tick && serve_term)) begin
                            ball_hold   <= 1'b0;
                            play_active <= 1'b1;
                            state       <= RS_PLAY;
                        end
                    end
                    RS_PLAY: begin
                        if (brick_hit) begin
                            if (bricks_left != 7'd0) begin
                                bricks_left <= bricks_left - 7'd1;
                            end
                            score <= score_sum[16] ? 16'hFFFF
                                                   : score_sum[15:0];
                        end
                        // A clearing hit outranks a simultaneous miss.
                        if (last_brick) begin
                            play_active <= 1'b0;
                            win         <= 1'b1;
                            state       <= RS_WIN;
                        end else if (ball_lost) begin
                            play_active <= 1'b0;
                            if (lives > 2'd1) begin
                                lives     <= lives - 2'd1;
                                ball_hold <= 1'b1;
                                state     <= RS_SERVE;
                            end else begin
                                lives <= 2'd0;
                                lose  <= 1'b1;
                                state <= RS_LOSE;
                            end
                        end
                    end
                    RS_WIN, RS_LOSE: begin
                        state <= RS_DONE;
                    end
                    RS_DONE: begin
                        state <= RS_DONE;
                    end
                    default: begin
                        state <= RS_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Testbench for round_ctrl: directed vector table, corner
// sequences and randomized traffic against a reference model.
module tb_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  screen_state;
    logic        brick_hit;
    logic        ball_lost;
    logic        launch_btn;
    logic        frame_tick;
    logic        win;
    logic        lose;
    logic        ball_hold;
    logic        play_active;
    logic [1:0]  lives;
    logic [6:0]  bricks_left;
    logic [15:0] score;

    logic [28:0] dut_out;

    int n_checks;
    int n_err;

    round_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .screen_state(screen_state),
        .brick_hit   (brick_hit),
        .ball_lost   (ball_lost),
        .launch_btn  (launch_btn),
        .frame_tick  (frame_tick),
        .win         (win),
        .lose        (lose),
        .ball_hold   (ball_hold),
        .play_active (play_active),
        .lives       (lives),
        .bricks_left (bricks_left),
        .score       (score)
    );

    assign dut_out = {win, lose, ball_hold, play_active,
                      lives, bricks_left, score};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: round phase plus counters.
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_SERVE = 2;
    localparam int P_PLAY  = 3;
    localparam int P_WIN   = 4;
    localparam int P_LOSE  = 5;
    localparam int P_DONE  = 6;

    int m_phase;
    int m_lives;
    int m_bricks;
    int m_score;
    int m_frames;

    function automatic logic [28:0] ex(
        input bit w, input bit lo, input bit hd, input bit pl,
        input int lv, input int bk, input int sc);
        return {w, lo, hd, pl, 2'(lv), 7'(bk), 16'(sc)};
    endfunction

    function automatic logic [28:0] model_out();
        return ex(m_phase == P_WIN, m_phase == P_LOSE,
                  m_phase == P_SERVE, m_phase == P_PLAY,
                  m_lives, m_bricks, m_score);
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_lives  = 0;
        m_bricks = 0;
        m_score  = 0;
        m_frames = 0;
    endtask

    task automatic model_step(input int s, input bit h,
                              input bit l, input bit b, input bit t);
        bit lvl;
        bit last;
        lvl = (s >= 3) && (s <= 10);
        if (m_phase != P_IDLE && !lvl) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: if (lvl) m_phase = P_LOAD;
            P_LOAD: begin
                m_lives  = 3;
                m_bricks = 8 * (s - 2);
                m_score  = 0;
                m_frames = 0;
                m_phase  = P_SERVE;
            end
            P_SERVE: begin
                if (b) begin
                    m_phase = P_PLAY;
                end else if (t) begin
                    m_frames++;
                    if (m_frames >= 120) m_phase = P_PLAY;
                end
            end
            P_PLAY: begin
                last = h && (m_bricks == 1);
                if (h) begin
                    if (m_bricks > 0) m_bricks--;
                    m_score = m_score + 10;
                    if (m_score > 65535) m_score = 65535;
                end
                if (last) begin
                    m_phase = P_WIN;
                end else if (l) begin
                    if (m_lives > 1) begin
                        m_lives--;
                        m_frames = 0;
                        m_phase  = P_SERVE;
                    end else begin
                        m_lives = 0;
                        m_phase = P_LOSE;
                    end
                end
            end
            P_WIN, P_LOSE: m_phase = P_DONE;
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [28:0] act,
                       input logic [28:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic h,
                        input logic l, input logic b, input logic t);
        @(negedge clk);
        screen_state = s;
        brick_hit    = h;
        ball_lost    = l;
        launch_btn   = b;
        frame_tick   = t;
        @(posedge clk);
        model_step(int'(s), h, l, b, t);
        #1;
    endtask

    typedef struct {
        logic [3:0]  s;
        logic        h;
        logic        l;
        logic        b;
        logic        t;
        logic [28:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        n_checks     = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        screen_state = 4'd3;
        brick_hit    = 1'b0;
        ball_lost    = 1'b0;
        launch_btn   = 1'b0;
        frame_tick   = 1'b0;
        model_reset();

        // Level 1: load, launch, clear all eight bricks, exit.
        tbl[0] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,0,0,0)};
        tbl[1] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0, ex(0,0,1,0,3,8,0)};
        tbl[2] = '{4'd3, 1'b0, 1'b0, 1'b1, 1'b0, ex(0,0,0,1,3,8,0)};
        for (int k = 1; k <= 7; k++) begin
            tbl[2 + k] = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                           ex(0,0,0,1,3,8 - k,10 * k)};
        end
        tbl[10] = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b0, ex(1,0,0,0,3,0,80)};
        tbl[11] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,3,0,80)};
        tbl[12] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,3,0,80)};
        tbl[13] = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,0,0,0)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset", dut_out, ex(0,0,0,0,0,0,0));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].h, tbl[i].l, tbl[i].b, tbl[i].t);
            chk($sformatf("vec%0d", i), dut_out, tbl[i].exp);
        end

        // Auto-launch after 120 frame ticks.
        step(4'd3, 0, 0, 0, 0);
        step(4'd3, 0, 0, 0, 0);
        chk("serve_entry", dut_out, ex(0,0,1,0,3,8,0));
        for (int k = 0; k < 119; k++) step(4'd3, 0, 0, 0, 1);
        chk("serve_tick119", dut_out, ex(0,0,1,0,3,8,0));
        step(4'd3, 0, 0, 0, 1);
        chk("serve_tick120", dut_out, ex(0,0,0,1,3,8,0));

        // Three misses.
        step(4'd3, 0, 1, 0, 0);
        chk("miss1", dut_out, ex(0,0,1,0,2,8,0));
        step(4'd3, 0, 0, 1, 0);
        chk("relaunch1", dut_out, ex(0,0,0,1,2,8,0));
        step(4'd3, 0, 1, 0, 0);
        chk("miss2", dut_out, ex(0,0,1,0,1,8,0));
        step(4'd3, 0, 0, 1, 0);
        step(4'd3, 0, 1, 0, 0);
        chk("miss3_lose", dut_out, ex(0,1,0,0,0,8,0));
        step(4'd3, 0, 0, 0, 0);
        chk("lose_done", dut_out, ex(0,0,0,0,0,8,0));
        step(4'd3, 0, 1, 1, 1);
        chk("done_hold", dut_out, ex(0,0,0,0,0,8,0));

        // Last brick and miss together.
        step(4'd1, 0, 0, 0, 0);
        step(4'd3, 0, 0, 0, 0);
        step(4'd3, 0, 0, 0, 0);
        step(4'd3, 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) step(4'd3, 1, 0, 0, 0);
        chk("one_left", dut_out, ex(0,0,0,1,3,1,70));
        step(4'd3, 1, 1, 0, 0);
        chk("hit_and_miss", dut_out, ex(1,0,0,0,3,0,80));
        step(4'd3, 0, 0, 0, 0);
        chk("win_done", dut_out, ex(0,0,0,0,3,0,80));

        // Screen exit mid-play, then level 8.
        step(4'd1, 0, 0, 0, 0);
        step(4'd3, 0, 0, 0, 0);
        step(4'd3, 0, 0, 0, 0);
        step(4'd3, 0, 0, 1, 0);
        step(4'd1, 1, 0, 0, 0);
        chk("exit_play", dut_out, ex(0,0,0,0,0,0,0));
        step(4'd10, 0, 0, 0, 0);
        chk("l8_load", dut_out, ex(0,0,0,0,0,0,0));
        step(4'd10, 0, 0, 0, 0);
        chk("l8_serve", dut_out, ex(0,0,1,0,3,64,0));

        // Asynchronous reset mid-level.
        step(4'd10, 0, 0, 1, 0);
        step(4'd10, 1, 0, 0, 0);
        chk("l8_hit", dut_out, ex(0,0,0,1,3,63,10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", dut_out, ex(0,0,0,0,0,0,0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'd10, 0, 0, 0, 0);
        step(4'd10, 0, 0, 0, 0);
        chk("rst_reload", dut_out, ex(0,0,1,0,3,64,0));

        // Randomized traffic against the model.
        begin
            logic [3:0] s;
            s = 4'd3;
            for (int i = 0; i < 5000; i++) begin
                if ($urandom_range(0, 63) == 0) begin
                    s = 4'($urandom_range(0, 12));
                end
                step(s,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 11) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 2) == 0);
                chk("rand", dut_out, model_out());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at level entry (1..3).
REQ-002 Parameter SERVE_FRAMES, default 120, frame ticks before auto-launch (1..255).
REQ-003 Parameter PTS_PER_BRICK, default 10, score increment per brick hit.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 screen_state  in  4  registered screen code from the screen FSM.
REQ-007 brick_hit  in  1  one-cycle pulse, one brick destroyed.
REQ-008 ball_lost  in  1  one-cycle pulse, ball passed the paddle.
REQ-009 launch_btn  in  1  synchronous, debounced launch request.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 win  out  1  one-cycle pulse, level cleared.
REQ-012 lose  out  1  one-cycle pulse, last life lost.
REQ-013 ball_hold  out  1  ball parked on paddle (serve phase).
REQ-014 play_active  out  1  ball/paddle physics enabled.
REQ-015 lives  out  2  remaining lives.
REQ-016 bricks_left  out  7  bricks remaining in current level.
REQ-017 score  out  16  current level score.

Function
REQ-018 Level codes: 3..10 = levels 1..8; level index = screen_state - 2; other codes are non-level screens.
REQ-019 FSM states: IDLE, LOAD, SERVE, PLAY, WIN, LOSE, DONE; all registered, single always_ff for state and counters.
REQ-020 IDLE: all outputs 0; next cycle screen_state is a level code -> LOAD.
REQ-021 LOAD (one cycle): bricks_left = 8 * level index, lives = LIVES_INIT, score = 0, serve counter = 0; -> SERVE.
REQ-022 SERVE: ball_hold = 1, play_active = 0; serve counter increments on frame_tick.
REQ-023 SERVE -> PLAY on launch_btn, or on frame_tick with serve counter == SERVE_FRAMES-1; launch_btn wins if both.
REQ-024 PLAY: play_active = 1, ball_hold = 0.
REQ-025 PLAY brick_hit: bricks_left decrements (saturates at 0); score += PTS_PER_BRICK (saturates at 16'hFFFF).
REQ-026 PLAY: bricks_left reaching 0 via brick_hit -> WIN the following cycle.
REQ-027 PLAY ball_lost with lives > 1: lives decrements, serve counter cleared, -> SERVE.
REQ-028 PLAY ball_lost with lives == 1: lives = 0, -> LOSE.
REQ-029 brick_hit on last brick and ball_lost in same cycle: brick counted, lives unchanged, -> WIN.
REQ-030 brick_hit and ball_lost ignored outside PLAY.
REQ-031 WIN: win = 1 for exactly one cycle; LOSE: lose = 1 for exactly one cycle; both -> DONE.
REQ-032 DONE: play_active = 0, ball_hold = 0, lives/bricks_left/score held; screen_state non-level -> IDLE.
REQ-033 Any state except IDLE: screen_state non-level -> IDLE next cycle, no win/lose pulse.
REQ-034 win and lose never asserted together; each at most once per level entry.

Reset
REQ-035 rst_n low: state = IDLE; win, lose, ball_hold, play_active, lives, bricks_left, score, serve counter all 0, asynchronously.
REQ-036 Reset deassertion mid-level: block re-enters via IDLE -> LOAD, restarting the level with full lives.

Structure
REQ-037 Shared package game_pkg: screen codes (SM, LS, GO, L1..L8), round FSM state enum, LIVES_INIT/SERVE_FRAMES defaults, brick-per-level multiplier (8).
REQ-038 One sub-module: serve_timer (frame-tick counter with clear, terminal-count flag), instantiated once.

Verification
REQ-039 rst_n low, screen_state=3 -> all outputs 0; release -> LOAD then SERVE with lives=3, bricks_left=8, ball_hold=1.
REQ-040 Level 1, launch_btn in SERVE, 8 brick_hit pulses -> score=80, bricks_left=0, single win pulse, then DONE.
REQ-041 No launch_btn, 120 frame_ticks in SERVE -> PLAY entered on the 120th tick.
REQ-042 Three ball_lost in PLAY (relaunching each time) -> lives 2,1,0, single lose pulse after third.
REQ-043 Level 1 with bricks_left=1, brick_hit and ball_lost same cycle -> win pulse, lives unchanged, no lose.
REQ-044 screen_state to 1 (LS) during PLAY -> IDLE next cycle, no win/lose; return to 10 -> bricks_left=64, lives=3.
